pipe_stage_buffer: RTL and testbench

Parametrised successor to the fixed per-stage pipeline latches between fetch, decode, execute, memory and writeback. It replaces each stage latch with a DEPTH-entry elastic buffer that carries a generic DATA_W payload, such as a packed fetch/decode/execute/memory stage struct. The buffer uses a valid/ready handshake, a synchronous flush for branch and exception redirects, bubble (NOP) injection when empty, and a saturating stall counter for performance analysis.

---
 rtl/pipe_stage_buffer.sv | 95 +++++++++
 tb/tb_pipe_stage_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage buffer: DEPTH-entry FIFO with flush, bubble output and stall counter.
// Latency: 1 cycle from push to head (no bypass); out_data is combinational from storage.
// Backpressure: in_ready drops when full (or follows out_ready when full and PASS_READY=1).
module pipe_stage_buffer #(
  parameter int                DATA_W     = 128,
  parameter int                DEPTH      = 2,
  parameter bit                PASS_READY = 1'b0,
  parameter logic [DATA_W-1:0] BUBBLE     = '0,
  parameter int                CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  // A single-entry buffer still needs a 1-bit pointer so the index is well formed.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0]    LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              push;
  logic              pop;
  logic              not_empty;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode; in_ready looks only at occupancy and (optionally) out_ready.
  always_comb begin
    not_empty = (count != '0);
    in_ready  = (count < DEPTH_C) || (PASS_READY && out_ready);
    out_valid = not_empty && !flush;
    out_data  = not_empty ? mem[rd_ptr] : BUBBLE;
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready;
  end

  // Payload storage; entries are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Occupancy and pointer state; flush empties the buffer and rewinds both pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of cycles where a valid head was held back by downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (not_empty && !flush && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: four configurations driven by shared stimulus.
// Each instance is compared every cycle against a queue-style reference model.
// Directed steps follow the buffer's key scenarios, then a randomized phase.
module tb_pipe_stage_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        ir [4];
  logic        ov [4];
  logic [15:0] od [4];
  logic [1:0]  c0;
  logic [0:0]  c1;
  logic [1:0]  c2;
  logic [2:0]  c3;
  logic [31:0] s0;
  logic [31:0] s1;
  logic [2:0]  s2;
  logic [31:0] s3;

  logic [63:0] obs_cnt [4];
  logic [63:0] obs_st  [4];

  int checks   = 0;
  int failures = 0;

  // Reference model: per-instance contents kept front-aligned (index 0 = oldest).
  logic [15:0] mq  [4][8];
  int          msz [4];
  longint      mst [4];

  pipe_stage_buffer #(.DATA_W(16), .DEPTH(2), .PASS_READY(1'b0), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .flush(flush),
    .count(c0), .stall_cnt(s0));
  pipe_stage_buffer #(.DATA_W(16), .DEPTH(1), .PASS_READY(1'b1), .BUBBLE(16'hB0B0), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .flush(flush),
    .count(c1), .stall_cnt(s1));
  pipe_stage_buffer #(.DATA_W(16), .DEPTH(3), .PASS_READY(1'b0), .CNT_W(3)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .flush(flush),
    .count(c2), .stall_cnt(s2));
  pipe_stage_buffer #(.DATA_W(16), .DEPTH(4), .PASS_READY(1'b1), .BUBBLE(16'hCAFE), .CNT_W(32)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .flush(flush),
    .count(c3), .stall_cnt(s3));

  // Widen the differently-sized count/stall outputs for uniform comparison.
  always_comb begin
    obs_cnt[0] = 64'(c0);
    obs_cnt[1] = 64'(c1);
    obs_cnt[2] = 64'(c2);
    obs_cnt[3] = 64'(c3);
    obs_st[0]  = 64'(s0);
    obs_st[1]  = 64'(s1);
    obs_st[2]  = 64'(s2);
    obs_st[3]  = 64'(s3);
  end

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int p_depth(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit p_pass(input int i);
    return (i == 1) || (i == 3);
  endfunction

  function automatic logic [15:0] p_bubble(input int i);
    case (i)
      1: return 16'hB0B0;
      3: return 16'hCAFE;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic longint p_max(input int i);
    return (i == 2) ? 64'd7 : 64'd4294967295;
  endfunction

  task automatic check(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      msz[i] = 0;
      mst[i] = 0;
    end
  endtask

  // One clock cycle: drive inputs, check every instance against the model, advance the model.
  task automatic cyc(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_od;
    int          old_sz;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    for (int i = 0; i < 4; i++) begin
      old_sz = msz[i];
      e_ir = (old_sz < p_depth(i)) || (p_pass(i) && ordy);
      e_ov = (old_sz > 0) && !fl;
      e_od = (old_sz > 0) ? mq[i][0] : p_bubble(i);
      check("in_ready", i, 64'(ir[i]), 64'(e_ir));
      check("out_valid", i, 64'(ov[i]), 64'(e_ov));
      check("out_data", i, 64'(od[i]), 64'(e_od));
      check("count", i, obs_cnt[i], 64'(old_sz));
      check("stall_cnt", i, obs_st[i], 64'(mst[i]));
      if (fl) begin
        msz[i] = 0;
      end else begin
        if (e_ov && ordy) begin
          for (int k = 0; k < old_sz - 1; k++) mq[i][k] = mq[i][k+1];
          msz[i]--;
        end
        if (iv && e_ir) begin
          mq[i][msz[i]] = d;
          msz[i]++;
        end
      end
      if ((old_sz > 0) && !fl && !ordy && (mst[i] < p_max(i))) mst[i]++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);

    // Fill/drain on the DEPTH=2, PASS_READY=0 instance.
    do_reset();
    cyc(1'b1, 16'h000A, 1'b0, 1'b0);
    cyc(1'b1, 16'h000B, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 16'h000C; out_ready = 1'b0;
    #1;
    check("fill_count", 0, obs_cnt[0], 64'd2);
    check("fill_in_ready", 0, 64'(ir[0]), 64'd0);
    check("fill_head", 0, 64'(od[0]), 64'h000A);
    cyc(1'b1, 16'h000C, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    in_valid = 1'b0;
    #1;
    check("drain_count", 0, obs_cnt[0], 64'd0);
    check("drain_bubble", 0, 64'(od[0]), 64'h0000);

    // Streaming through the single-entry pass-ready instance.
    do_reset();
    for (int k = 1; k <= 8; k++) cyc(1'b1, 16'(k), 1'b1, 1'b0);
    #1;
    check("stream_count", 1, obs_cnt[1], 64'd1);
    check("stream_head", 1, 64'(od[1]), 64'd8);

    // Stall counting and saturation.
    do_reset();
    cyc(1'b1, 16'h0055, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    check("stall_5", 0, obs_st[0], 64'd5);
    repeat (5) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    check("stall_sat", 2, obs_st[2], 64'd7);
    check("stall_10", 0, obs_st[0], 64'd10);

    // Flush with a concurrent push on the DEPTH=4 instance.
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b1, 16'(16'h0030 + k), 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 16'h000F; out_ready = 1'b1; flush = 1'b1;
    #1;
    check("flush_out_valid", 3, 64'(ov[3]), 64'd0);
    check("flush_in_ready", 3, 64'(ir[3]), 64'd1);
    cyc(1'b1, 16'h000F, 1'b1, 1'b1);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_count", 3, obs_cnt[3], 64'd0);
    check("flush_bubble", 3, 64'(od[3]), 64'hCAFE);
    repeat (3) cyc(1'b0, 16'h0, 1'b1, 1'b0);

    // Pointer wrap with interleaved stalls.
    do_reset();
    for (int k = 0; k < 10; k++) cyc(1'b1, 16'(16'h0100 + k), (k % 3) != 0, 1'b0);
    repeat (5) cyc(1'b0, 16'h0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges with entries held.
    do_reset();
    cyc(1'b1, 16'h0071, 1'b0, 1'b0);
    cyc(1'b1, 16'h0072, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", 0, 64'(ov[0]), 64'd0);
    check("arst_count", 0, obs_cnt[0], 64'd0);
    check("arst_stall", 0, obs_st[0], 64'd0);
    check("arst_in_ready", 0, 64'(ir[0]), 64'd1);
    check("arst_bubble", 3, 64'(od[3]), 64'hCAFE);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 16'h0099, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes.
    do_reset();
    repeat (400) begin
      cyc(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
